cascade_counter: RTL and testbench
==================================

Name: cascade_counter

Overview:
- Parametrised successor to the single mod-M counter: a chain of N_STAGES modulo counters, each stage with its own modulus, cascaded ripple-free in one clock domain.
- Default configuration is the clock core: seconds (mod 60), minutes (mod 60), hours (mod 24).
- Adds capabilities the single counter lacks: synchronous clear, parallel load with range clamping, per-stage wrap pulses and a whole-chain terminal pulse.
- Feeds the display/decoder path directly.

Parameters:
- N_STAGES, 3, number of cascaded stages; stage 0 is least significant.
- W, 8, bits per stage field; every modulus must be <= 2^W.
- MODULI, {32'd24,32'd60,32'd60}, packed 32-bit moduli; bits [32i+31:32i] give stage i modulus M_i. Each M_i must be >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  count enable (one tick per cycle when high).
- dir  in  1  count direction: 0 = up, 1 = down. Only used when COUNTER_CHAIN_DOWN_EN is defined.
- clr  in  1  synchronous clear of all stages.
- load  in  1  synchronous parallel load.
- load_val  in  N_STAGES*W  load value; field i goes to stage i.
- count  out  N_STAGES*W  current stage values; field i is stage i.
- carry  out  N_STAGES  registered one-cycle wrap pulse per stage.
- tc  out  1  registered one-cycle pulse when the whole chain wraps.
- load_err  out  1  registered one-cycle pulse when any load field was out of range.

Behaviour:
- Reset (rst_n low at a rising edge): count=0, carry=0, tc=0, load_err=0. Reset overrides every other input, including mid-load or mid-cascade.
- Priority, highest first: rst_n, clr, load, en. Inputs with lower priority are ignored in a cycle where a higher one is active.
- clr: all count fields become 0 on the next edge; carry, tc and load_err are 0 in the following cycle.
- load: stage i takes load_val field i on the next edge.
  - If field i >= M_i, stage i takes M_i-1 instead (clamp).
  - load_err pulses in the following cycle if any field was clamped.
  - carry and tc stay 0 for a load cycle.
- Counting: en high, no clr, no load.
  - Stage 0 steps every cycle.
  - Stage i (i>0) steps only when every lower stage is at its terminal value in the same cycle. Terminal is M_j-1 when counting up, 0 when counting down.
  - Up at M_i-1: wrap to 0. Down at 0: wrap to M_i-1.
  - All stepping stages update on the same edge; no ripple delay between stages.
- carry[i]: high for exactly the one cycle after the edge on which stage i wrapped.
- tc: high in the cycle after all stages wrapped on the same edge. tc equals the AND of all carry bits.
- en low: counts hold; carry and tc return to 0 after one cycle.
- Latency: count reflects a clr/load/en input one cycle after it is sampled. Pulses share that latency.
- Stage arithmetic is W bits wide. The compare with M_i uses W+1 bits so that M_i = 2^W is handled correctly.

Optional Feature:
- Macro: COUNTER_CHAIN_DOWN_EN.
- Defined: dir selects up or down counting as described above. A dir change takes effect on the next counting edge with no extra cycle.
- Undefined: dir is ignored and the chain counts up only. The down-count compare and wrap logic is not synthesised.
- Reset, clr, load and clamp behaviour are identical in both builds.

Decomposition:
- Package counter_pkg holds:
  - default clock moduli constants SEC_MOD=60, MIN_MOD=60, HR_MOD=24;
  - the default field width W=8;
  - a function mod_of(MODULI, i) that extracts M_i.
- Sub-module counter_stage, instantiated N_STAGES times by a generate loop:
  - inputs: modulus, step, dir, clr, load, load value;
  - outputs: value, terminal flag (combinational), wrap flag.
- The top level forms the step chain as a running AND of the terminal flags and registers the carry, tc and load_err pulses.

Test Plan:
- rst_n low for 2 cycles with en=1 -> count=0, carry=0, tc=0. Release -> stage 0 reads 1 after the first edge.
- Default build, load {23,59,58}, then en for 2 cycles:
  - after edge 1: count = {23,59,59};
  - after edge 2: count = {0,0,0}, carry=3'b111 and tc=1 for exactly one cycle.
- Load {30,70,5} -> count = {23,59,5} and load_err pulses once; carry=0, tc=0.
- Count running with load, clr and en all high in the same cycle -> count=0 (clr wins). Then load alone with en=1 -> loaded value held that cycle, no increment.
- COUNTER_CHAIN_DOWN_EN defined, dir=1, count {0,0,0}, en for 1 cycle -> count = {23,59,59} with carry=3'b111. Repeat with the macro undefined -> count = {0,0,1}.
- rst_n asserted in the same cycle as load=1 -> count=0 and load_err=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the cascaded modulo counter (clock core by default).
// The optional down-count build is selected with COUNTER_CHAIN_DOWN_EN.
package counter_pkg;

  localparam int unsigned SEC_MOD    = 60;
  localparam int unsigned MIN_MOD    = 60;
  localparam int unsigned HR_MOD     = 24;
  localparam int unsigned DEF_W      = 8;
  localparam int unsigned MAX_STAGES = 16;

  // Stage 0 in the low word: seconds, minutes, hours.
  localparam logic [95:0] CLOCK_MODULI = {32'(HR_MOD), 32'(MIN_MOD), 32'(SEC_MOD)};

  // Extract modulus M_i from a packed moduli vector zero-extended to MAX_STAGES words.
  function automatic logic [31:0] mod_of(input logic [32*MAX_STAGES-1:0] moduli,
                                         input int unsigned i);
    return moduli[32*i +: 32];
  endfunction

endpackage

// File: rtl/counter_stage.sv
// One modulo-M stage of the cascade: clear, clamped load and single-step with wrap.
// Down counting exists only when COUNTER_CHAIN_DOWN_EN is defined.
module counter_stage
  import counter_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W:0]   modulus,
  input  logic         step,
  input  logic         dir,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         terminal,
  output logic         wrap,
  output logic         clamped
);

  logic [W-1:0] value_q, value_d;
  logic [W:0]   mod_m1;
  logic [W-1:0] max_val;
  logic         at_max;

  // W+1-bit compares keep a modulus of exactly 2^W representable.
  assign mod_m1  = modulus - 1'b1;
  assign max_val = mod_m1[W-1:0];
  assign at_max  = ({1'b0, value_q} == mod_m1);
  assign clamped = ({1'b0, load_val} >= modulus);

`ifdef COUNTER_CHAIN_DOWN_EN
  assign terminal = dir ? (value_q == '0) : at_max;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign terminal   = at_max;
`endif

  assign wrap = step & terminal & ~clr & ~load;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (load) begin
      value_d = clamped ? max_val : load_val;
    end else if (step) begin
`ifdef COUNTER_CHAIN_DOWN_EN
      if (dir) value_d = terminal ? max_val : value_q - 1'b1;
      else     value_d = terminal ? '0 : value_q + 1'b1;
`else
      value_d = terminal ? '0 : value_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/cascade_counter.sv
// Chain of N_STAGES modulo counters stepping on a single edge, with wrap/terminal/load-error pulses.
// Define COUNTER_CHAIN_DOWN_EN to honour dir (down counting); otherwise dir is ignored.
module cascade_counter
  import counter_pkg::*;
#(
  parameter int unsigned                N_STAGES = 3,
  parameter int unsigned                W        = DEF_W,
  parameter logic [32*N_STAGES-1:0]     MODULI   = CLOCK_MODULI
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  clr,
  input  logic                  load,
  input  logic [N_STAGES*W-1:0] load_val,
  output logic [N_STAGES*W-1:0] count,
  output logic [N_STAGES-1:0]   carry,
  output logic                  tc,
  output logic                  load_err
);

  localparam logic [32*MAX_STAGES-1:0] MODULI_EXT = (32*MAX_STAGES)'(MODULI);

  logic [N_STAGES-1:0] step;
  logic [N_STAGES-1:0] terminal;
  logic [N_STAGES-1:0] wrap;
  logic [N_STAGES-1:0] clamped;

  logic [N_STAGES-1:0] carry_q, carry_d;
  logic                tc_q, tc_d;
  logic                load_err_q, load_err_d;

  // Counting only happens when neither clr nor load claims the cycle.
  assign step[0] = en & ~clr & ~load;

  // The top stage's terminal flag has no stage above it to enable.
  logic unused_top_terminal;
  assign unused_top_terminal = terminal[N_STAGES-1];

  generate
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
      localparam logic [W:0] MOD_I = (W+1)'(mod_of(MODULI_EXT, gi));

      if (gi > 0) begin : g_chain
        // Running AND: a stage steps only when every lower stage is terminal this cycle.
        assign step[gi] = step[gi-1] & terminal[gi-1];
      end

      counter_stage #(
        .W (W)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .modulus  (MOD_I),
        .step     (step[gi]),
        .dir      (dir),
        .clr      (clr),
        .load     (load),
        .load_val (load_val[W*gi +: W]),
        .value    (count[W*gi +: W]),
        .terminal (terminal[gi]),
        .wrap     (wrap[gi]),
        .clamped  (clamped[gi])
      );
    end
  endgenerate

  always_comb begin
    carry_d    = wrap;
    tc_d       = &wrap;
    load_err_d = load & ~clr & (|clamped);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q    <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      carry_q    <= carry_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign carry    = carry_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Scoreboard bench for cascade_counter in the default clock configuration (60/60/24).
// Expected down-count results follow COUNTER_CHAIN_DOWN_EN when the bench is built with it.
module tb_cascade_counter;

  typedef struct packed {
    logic [23:0] count;
    logic [2:0]  carry;
    logic        tc;
    logic        lerr;
  } obs_t;

  typedef struct {
    bit          rn, e, d, c, l;
    logic [23:0] lv;
    bit          chk;
    obs_t        cexp;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
  logic [23:0] load_val = '0;
  logic [23:0] count;
  logic [2:0]  carry;
  logic        tc, load_err;

  obs_t sb[$];
  int   ms[3];
  int   mods[3] = '{60, 60, 24};
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cascade_counter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .carry    (carry),
    .tc       (tc),
    .load_err (load_err)
  );

  function automatic string fmt(input obs_t o);
    return $sformatf("count=%h carry=%b tc=%b load_err=%b", o.count, o.carry, o.tc, o.lerr);
  endfunction

  function automatic obs_t sample();
    return obs_t'{count, carry, tc, load_err};
  endfunction

  // Apply one cycle of inputs, advance the reference model and queue its prediction.
  task automatic drive(input stim_t s);
    obs_t x;
    bit   stp, term, dn;
    int   f;
    @(negedge clk);
    rst_n = s.rn; en = s.e; dir = s.d; clr = s.c; load = s.l; load_val = s.lv;
    x  = '0;
    dn = 1'b0 & s.d;
`ifdef COUNTER_CHAIN_DOWN_EN
    dn = s.d;
`endif
    if (!s.rn || s.c) begin
      for (int i = 0; i < 3; i++) ms[i] = 0;
    end else if (s.l) begin
      for (int i = 0; i < 3; i++) begin
        f = int'(s.lv[8*i +: 8]);
        if (f >= mods[i]) begin
          ms[i] = mods[i] - 1;
          x.lerr = 1'b1;
        end else begin
          ms[i] = f;
        end
      end
    end else if (s.e) begin
      stp = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (stp) begin
          term = dn ? (ms[i] == 0) : (ms[i] == mods[i] - 1);
          if (term) begin
            ms[i] = dn ? mods[i] - 1 : 0;
            x.carry[i] = 1'b1;
          end else begin
            ms[i] = dn ? ms[i] - 1 : ms[i] + 1;
          end
          stp = term;
        end
      end
    end
    x.count = {ms[2][7:0], ms[1][7:0], ms[0][7:0]};
    x.tc    = &x.carry;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t t[$];
    obs_t  got, exp;
    t.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h000000, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h000000, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h000001, 3'b000, 1'b0, 1'b0}});
    foreach (t[k]) begin
      drive(t[k]);
      got = sample();
      exp = sb.pop_front();
      n_vec++;
      $display("vec %0d reset: rst_n=%0b en=%0b -> %s", n_vec, t[k].rn, t[k].e, fmt(got));
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_model: got %s need %s", fmt(got), fmt(exp));
      end
      if (t[k].chk) begin
        n_vec++;
        if (got !== t[k].cexp) begin
          n_err++;
          $display("FAIL reset_const: got %s need %s", fmt(got), fmt(t[k].cexp));
        end
      end
    end
  endtask

  task automatic test_wrap();
    stim_t t[$];
    obs_t  got, exp;
    t.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h173B3A, 1'b1, obs_t'{24'h173B3A, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h173B3B, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h000000, 3'b111, 1'b1, 1'b0}});
    t.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h000000, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h000001, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h003B3B, 1'b1, obs_t'{24'h003B3B, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h010000, 3'b011, 1'b0, 1'b0}});
    foreach (t[k]) begin
      drive(t[k]);
      got = sample();
      exp = sb.pop_front();
      n_vec++;
      $display("vec %0d wrap: en=%0b load=%0b lv=%h -> %s", n_vec, t[k].e, t[k].l, t[k].lv, fmt(got));
      if (got !== exp) begin
        n_err++;
        $display("FAIL wrap_model: got %s need %s", fmt(got), fmt(exp));
      end
      if (t[k].chk) begin
        n_vec++;
        if (got !== t[k].cexp) begin
          n_err++;
          $display("FAIL wrap_const: got %s need %s", fmt(got), fmt(t[k].cexp));
        end
      end
    end
  endtask

  task automatic test_clamp();
    stim_t t[$];
    obs_t  got, exp;
    t.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h1E4605, 1'b1, obs_t'{24'h173B05, 3'b000, 1'b0, 1'b1}});
    t.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h173B05, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0A3B3C, 1'b1, obs_t'{24'h0A3B3B, 3'b000, 1'b0, 1'b1}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h173B00, 1'b1, obs_t'{24'h173B00, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h183C3C, 1'b1, obs_t'{24'h173B3B, 3'b000, 1'b0, 1'b1}});
    t.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 1'b1, obs_t'{24'h173B3B, 3'b000, 1'b0, 1'b1}});
    foreach (t[k]) begin
      drive(t[k]);
      got = sample();
      exp = sb.pop_front();
      n_vec++;
      $display("vec %0d clamp: load=%0b lv=%h -> %s", n_vec, t[k].l, t[k].lv, fmt(got));
      if (got !== exp) begin
        n_err++;
        $display("FAIL clamp_model: got %s need %s", fmt(got), fmt(exp));
      end
      if (t[k].chk) begin
        n_vec++;
        if (got !== t[k].cexp) begin
          n_err++;
          $display("FAIL clamp_const: got %s need %s", fmt(got), fmt(t[k].cexp));
        end
      end
    end
  endtask

  task automatic test_priority();
    stim_t t[$];
    obs_t  got, exp;
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0, 1'b1, obs_t'{24'h000000, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, obs_t'{24'h0, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, obs_t'{24'h0, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h000003, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h1E4605, 1'b1, obs_t'{24'h000000, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h02030A, 1'b1, obs_t'{24'h02030A, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h02030B, 3'b000, 1'b0, 1'b0}});
    foreach (t[k]) begin
      drive(t[k]);
      got = sample();
      exp = sb.pop_front();
      n_vec++;
      $display("vec %0d priority: en=%0b clr=%0b load=%0b lv=%h -> %s",
               n_vec, t[k].e, t[k].c, t[k].l, t[k].lv, fmt(got));
      if (got !== exp) begin
        n_err++;
        $display("FAIL priority_model: got %s need %s", fmt(got), fmt(exp));
      end
      if (t[k].chk) begin
        n_vec++;
        if (got !== t[k].cexp) begin
          n_err++;
          $display("FAIL priority_const: got %s need %s", fmt(got), fmt(t[k].cexp));
        end
      end
    end
  endtask

  task automatic test_down();
    stim_t t[$];
    obs_t  got, exp;
    t.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b1, obs_t'{24'h000000, 3'b000, 1'b0, 1'b0}});
`ifdef COUNTER_CHAIN_DOWN_EN
    t.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h173B3B, 3'b111, 1'b1, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h173B3A, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h173B3B, 3'b000, 1'b0, 1'b0}});
`else
    t.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h000001, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h000002, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h000003, 3'b000, 1'b0, 1'b0}});
`endif
    foreach (t[k]) begin
      drive(t[k]);
      got = sample();
      exp = sb.pop_front();
      n_vec++;
      $display("vec %0d down: en=%0b dir=%0b clr=%0b -> %s", n_vec, t[k].e, t[k].d, t[k].c, fmt(got));
      if (got !== exp) begin
        n_err++;
        $display("FAIL down_model: got %s need %s", fmt(got), fmt(exp));
      end
      if (t[k].chk) begin
        n_vec++;
        if (got !== t[k].cexp) begin
          n_err++;
          $display("FAIL down_const: got %s need %s", fmt(got), fmt(t[k].cexp));
        end
      end
    end
  endtask

  task automatic test_reset_load();
    stim_t t[$];
    obs_t  got, exp;
    t.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h173B3B, 1'b1, obs_t'{24'h173B3B, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h1E4605, 1'b1, obs_t'{24'h000000, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h173B3B, 1'b0, obs_t'{24'h0, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h000000, 3'b000, 1'b0, 1'b0}});
    t.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, obs_t'{24'h000001, 3'b000, 1'b0, 1'b0}});
    foreach (t[k]) begin
      drive(t[k]);
      got = sample();
      exp = sb.pop_front();
      n_vec++;
      $display("vec %0d reset_load: rst_n=%0b load=%0b lv=%h -> %s", n_vec, t[k].rn, t[k].l, t[k].lv, fmt(got));
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_load_model: got %s need %s", fmt(got), fmt(exp));
      end
      if (t[k].chk) begin
        n_vec++;
        if (got !== t[k].cexp) begin
          n_err++;
          $display("FAIL reset_load_const: got %s need %s", fmt(got), fmt(t[k].cexp));
        end
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    obs_t  got, exp;
    for (int k = 0; k < 400; k++) begin
      s.rn  = ($urandom_range(0, 59) != 0);
      s.c   = ($urandom_range(0, 29) == 0);
      s.l   = ($urandom_range(0, 11) == 0);
      s.e   = ($urandom_range(0, 3) != 0);
      s.d   = ((k / 50) % 2 == 1);
      s.lv  = {8'($urandom_range(20, 25)), 8'($urandom_range(55, 62)), 8'($urandom_range(50, 63))};
      s.chk = 1'b0;
      s.cexp = '0;
      drive(s);
      got = sample();
      exp = sb.pop_front();
      n_vec++;
      $display("vec %0d random: rst_n=%0b en=%0b dir=%0b clr=%0b load=%0b lv=%h -> %s",
               n_vec, s.rn, s.e, s.d, s.c, s.l, s.lv, fmt(got));
      if (got !== exp) begin
        n_err++;
        $display("FAIL random_model: got %s need %s", fmt(got), fmt(exp));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) ms[i] = 0;
    test_reset();
    test_wrap();
    test_clamp();
    test_priority();
    test_down();
    test_reset_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
